// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single memory port between ICache line refills (read-only) and
// DCache reads/writes. Each access runs for MEM_LATENCY cycles in BUSY, then
// spends one cycle in DONE, where a one-cycle ready pulse goes to the cache
// that owns the access. When both caches request at the same time, the cache
// that did not win the previous grant is served (last-granted-loses).
//
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   ic_req/ic_addr          ICache read request (held until ic_ready)
//   ic_rdata/ic_ready       ICache read data, valid with the ready pulse
//   dc_req/dc_we/dc_addr/dc_wdata
//                           DCache request (held until dc_ready)
//   dc_rdata/dc_ready       DCache read data, valid with the ready pulse
//   mem_req/mem_we/mem_addr/mem_wdata
//                           memory access; stable for the whole access
//   mem_rdata               memory read data, valid on the last BUSY cycle
//   arb_busy                high whenever an access is in BUSY or DONE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128,
    parameter int MEM_LATENCY = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    // Count value on the final BUSY cycle, when mem_rdata is valid.
    localparam logic [3:0] LAST_COUNT = 4'(MEM_LATENCY - 1);

    logic [1:0]        state;
    logic [3:0]        count;
    logic              owner;
    logic              last_grant;
    logic [DATA_W-1:0] rdata_q;
    logic              pick_dc;

    // Arbitration decision: DCache wins when it is the only requester, or
    // when both request and the ICache was the last one served.
    always_comb begin
        pick_dc = dc_req & (~ic_req | (last_grant == OWNER_IC));
    end

    // Access sequencer: grant in IDLE, hold the captured access in BUSY,
    // pulse the owner's ready in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            owner      <= OWNER_IC;
            last_grant <= OWNER_IC;
            rdata_q    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ic_ready   <= 1'b0;
            dc_ready   <= 1'b0;
            arb_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        state      <= BUSY;
                        count      <= 4'd0;
                        owner      <= pick_dc;
                        last_grant <= pick_dc;
                        mem_req    <= 1'b1;
                        // ICache accesses are always reads.
                        mem_we     <= pick_dc & dc_we;
                        mem_addr   <= pick_dc ? dc_addr : ic_addr;
                        mem_wdata  <= pick_dc ? dc_wdata : '0;
                        arb_busy   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    count <= count + 4'd1;
                    if (count == LAST_COUNT) begin
                        // Loaded for writes too; the DCache ignores it then.
                        rdata_q  <= mem_rdata;
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        ic_ready <= (owner == OWNER_IC);
                        dc_ready <= (owner == OWNER_DC);
                    end else begin
                        state <= BUSY;
                    end
                end
                DONE: begin
                    // Requests are not sampled here, so a requester still
                    // holding req during its ready cycle is not re-granted.
                    state    <= IDLE;
                    ic_ready <= 1'b0;
                    dc_ready <= 1'b0;
                    arb_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    ic_ready <= 1'b0;
                    dc_ready <= 1'b0;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

    assign ic_rdata = rdata_q;
    assign dc_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Stimulus threads act as the two caches and
// push the expected memory accesses and ready responses into queues; a memory
// monitor and a response monitor pop and compare independently.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int LAT = 5;

    logic         clock;
    logic         reset;
    logic         ic_req;
    logic [31:0]  ic_addr;
    logic [127:0] ic_rdata;
    logic         ic_ready;
    logic         dc_req;
    logic         dc_we;
    logic [31:0]  dc_addr;
    logic [127:0] dc_wdata;
    logic [127:0] dc_rdata;
    logic         dc_ready;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         arb_busy;

    mem_arbiter #(.ADDR_W(32), .DATA_W(128), .MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ready(dc_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .arb_busy(arb_busy)
    );

    typedef struct {
        logic         port;   // 0 = ICache, 1 = DCache
        logic [127:0] data;
        int           cyc;
    } rsp_t;

    typedef struct {
        logic [31:0]  addr;
        logic         we;
        logic [127:0] wdata;
    } mem_t;

    rsp_t exp_rsp[$];
    mem_t exp_mem[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   mcnt   = 0;
    int   t0;

    localparam logic [127:0] GARBAGE = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;

    // Data the memory model returns for a given address on the last BUSY cycle.
    function automatic logic [127:0] mdata(input logic [31:0] a);
        return {32'hDEADBEEF, a, 32'h0000_0000, 32'h0000_0001};
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory model + monitor: valid data only on the LAT-th busy cycle.
    mem_t me;
    always @(negedge clock) begin
        if (mem_req) begin
            mcnt++;
            checks++;
            if (exp_mem.size() == 0) begin
                fails++;
                $display("FAIL mem_unexpected: addr=%h we=%b, required no access", mem_addr, mem_we);
            end else begin
                me = exp_mem[0];
                if (mem_addr !== me.addr || mem_we !== me.we || (me.we && mem_wdata !== me.wdata)) begin
                    fails++;
                    $display("FAIL mem_access: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                             mem_addr, mem_we, mem_wdata, me.addr, me.we, me.wdata);
                end
                if (mcnt == LAT) void'(exp_mem.pop_front());
            end
            mem_rdata = (mcnt == LAT) ? mdata(mem_addr) : GARBAGE;
        end else begin
            if (mcnt != 0 && !reset) begin
                checks++;
                if (mcnt != LAT) begin
                    fails++;
                    $display("FAIL mem_burst_len: got %0d cycles, required %0d", mcnt, LAT);
                end
            end
            mcnt = 0;
            mem_rdata = GARBAGE;
        end
    end

    // Response monitor: every ready pulse must match the head of exp_rsp.
    rsp_t re;
    logic [127:0] rd;
    always @(negedge clock) begin
        if (ic_ready || dc_ready) begin
            checks++;
            if (ic_ready && dc_ready) begin
                fails++;
                $display("FAIL rsp_both: got ic_ready=1 dc_ready=1, required one of them");
            end else if (exp_rsp.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected: got ic_ready=%b dc_ready=%b at cycle %0d, required none",
                         ic_ready, dc_ready, cyc);
            end else begin
                re = exp_rsp.pop_front();
                rd = dc_ready ? dc_rdata : ic_rdata;
                if (dc_ready !== re.port || rd !== re.data || cyc != re.cyc) begin
                    fails++;
                    $display("FAIL rsp: got port=%b data=%h cycle=%0d, required port=%b data=%h cycle=%0d",
                             dc_ready, rd, cyc, re.port, re.data, re.cyc);
                end
            end
        end
    end

    task automatic push_rsp(input logic port, input logic [31:0] a, input int c);
        rsp_t r;
        r.port = port; r.data = mdata(a); r.cyc = c;
        exp_rsp.push_back(r);
    endtask

    task automatic push_mem(input logic [31:0] a, input logic we, input logic [127:0] wd);
        mem_t m;
        m.addr = a; m.we = we; m.wdata = wd;
        exp_mem.push_back(m);
    endtask

    // ICache requester: hold req until ready, drop it in the following cycle.
    task automatic ic_access(input logic [31:0] a);
        int n;
        ic_req = 1'b1; ic_addr = a; n = 0;
        do begin
            @(negedge clock); n++;
        end while (!ic_ready && n < 60);
        if (!ic_ready) begin
            checks++; fails++;
            $display("FAIL ic_timeout: got no ic_ready for addr %h, required a pulse", a);
        end
        @(posedge clock); #1;
        ic_req = 1'b0;
    endtask

    // DCache requester: same handshake as the ICache plus write controls.
    task automatic dc_access(input logic [31:0] a, input logic we, input logic [127:0] wd);
        int n;
        dc_req = 1'b1; dc_addr = a; dc_we = we; dc_wdata = wd; n = 0;
        do begin
            @(negedge clock); n++;
        end while (!dc_ready && n < 60);
        if (!dc_ready) begin
            checks++; fails++;
            $display("FAIL dc_timeout: got no dc_ready for addr %h, required a pulse", a);
        end
        @(posedge clock); #1;
        dc_req = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({mem_req, arb_busy, ic_ready, dc_ready} !== 4'b0000 || mem_addr !== 32'h0 ||
            ic_rdata !== 128'h0 || dc_rdata !== 128'h0) begin
            fails++;
            $display("FAIL %s: got req=%b busy=%b icr=%b dcr=%b addr=%h rdata=%h, required all 0",
                     name, mem_req, arb_busy, ic_ready, dc_ready, mem_addr, ic_rdata);
        end
    endtask

    initial begin
        reset = 1'b1; ic_req = 1'b0; ic_addr = 32'h0; dc_req = 1'b0; dc_we = 1'b0;
        dc_addr = 32'h0; dc_wdata = 128'h0; mem_rdata = GARBAGE;
        repeat (3) @(posedge clock);
        #1;
        check_quiet("reset_state");
        reset = 1'b0;
        settle();

        // Single ICache read; dc_we left high must not leak into mem_we.
        dc_we = 1'b1;
        t0 = cyc;
        push_mem(32'h0000_0040, 1'b0, 128'h0);
        push_rsp(1'b0, 32'h0000_0040, t0 + 6);
        ic_access(32'h0000_0040);
        settle();

        // DCache write.
        t0 = cyc;
        push_mem(32'h0000_0100, 1'b1, 128'h1234);
        push_rsp(1'b1, 32'h0000_0100, t0 + 6);
        dc_access(32'h0000_0100, 1'b1, 128'h1234);
        settle();

        // Conflict straight after reset: DCache first.
        reset = 1'b1; #2; reset = 1'b0;
        settle();
        t0 = cyc;
        push_mem(32'h0000_0300, 1'b0, 128'h0);
        push_mem(32'h0000_0340, 1'b0, 128'h0);
        push_rsp(1'b1, 32'h0000_0300, t0 + 6);
        push_rsp(1'b0, 32'h0000_0340, t0 + 13);
        fork
            ic_access(32'h0000_0340);
            dc_access(32'h0000_0300, 1'b0, 128'h0);
        join
        settle();

        // Alternation: both re-request right after each completion -> D, I, D, I.
        t0 = cyc;
        push_mem(32'h0000_0400, 1'b0, 128'h0);
        push_mem(32'h0000_0500, 1'b0, 128'h0);
        push_mem(32'h0000_0410, 1'b0, 128'h0);
        push_mem(32'h0000_0510, 1'b0, 128'h0);
        push_rsp(1'b1, 32'h0000_0400, t0 + 6);
        push_rsp(1'b0, 32'h0000_0500, t0 + 13);
        push_rsp(1'b1, 32'h0000_0410, t0 + 20);
        push_rsp(1'b0, 32'h0000_0510, t0 + 27);
        fork
            begin
                dc_access(32'h0000_0400, 1'b0, 128'h0);
                @(posedge clock); #1;
                dc_access(32'h0000_0410, 1'b0, 128'h0);
            end
            begin
                ic_access(32'h0000_0500);
                @(posedge clock); #1;
                ic_access(32'h0000_0510);
            end
        join
        settle();

        // Lone DCache access, then a conflict: the ICache must win this time.
        t0 = cyc;
        push_mem(32'h0000_0600, 1'b1, 128'h55AA);
        push_rsp(1'b1, 32'h0000_0600, t0 + 6);
        dc_access(32'h0000_0600, 1'b1, 128'h55AA);
        settle();
        t0 = cyc;
        push_mem(32'h0000_0700, 1'b0, 128'h0);
        push_mem(32'h0000_0780, 1'b1, 128'h9876);
        push_rsp(1'b0, 32'h0000_0700, t0 + 6);
        push_rsp(1'b1, 32'h0000_0780, t0 + 13);
        fork
            ic_access(32'h0000_0700);
            dc_access(32'h0000_0780, 1'b1, 128'h9876);
        join
        settle();

        // Late DCache arrival during an ICache access; ic_addr also changes mid-access.
        t0 = cyc;
        push_mem(32'h0000_0800, 1'b0, 128'h0);
        push_mem(32'h0000_0900, 1'b0, 128'h0);
        push_rsp(1'b0, 32'h0000_0800, t0 + 6);
        push_rsp(1'b1, 32'h0000_0900, t0 + 13);
        fork
            ic_access(32'h0000_0800);
            begin
                repeat (2) @(posedge clock); #1;
                dc_access(32'h0000_0900, 1'b0, 128'h0);
            end
            begin
                repeat (3) @(posedge clock); #1;
                ic_addr = 32'hFFFF_0000;
            end
        join
        settle();

        // Reset in the third cycle of an access: everything drops at once.
        t0 = cyc;
        push_mem(32'h0000_0A00, 1'b0, 128'h0);
        ic_req = 1'b1; ic_addr = 32'h0000_0A00;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_quiet("reset_mid_busy");
        ic_req = 1'b0;
        exp_mem.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        settle();
        t0 = cyc;
        push_mem(32'h0000_0B00, 1'b0, 128'h0);
        push_rsp(1'b0, 32'h0000_0B00, t0 + 6);
        ic_access(32'h0000_0B00);
        settle();

        checks++;
        if (exp_rsp.size() != 0 || exp_mem.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d responses and %0d accesses outstanding, required 0 and 0",
                     exp_rsp.size(), exp_mem.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single instruction/data memory port between ICache refills and DCache reads/writes.
- Sits between both caches and the memory model, replacing direct cache-to-memory wiring.
- Sequences each access over a fixed memory latency and returns a one-cycle ready pulse to the owning cache.
- Breaks conflicts with alternating (last-granted-loses) priority.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 128, line/transfer width for rdata and wdata.
- MEM_LATENCY, 5, memory access cycles (BUSY state length); legal range 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ic_req  in  1  ICache read request; held until ic_ready
- ic_addr  in  ADDR_W  ICache line address
- ic_rdata  out  DATA_W  read data; valid only while ic_ready=1
- ic_ready  out  1  one-cycle completion pulse to ICache
- dc_req  in  1  DCache request; held until dc_ready
- dc_we  in  1  1 = write, 0 = read
- dc_addr  in  ADDR_W  DCache address
- dc_wdata  in  DATA_W  DCache write data
- dc_rdata  out  DATA_W  read data; valid only while dc_ready=1
- dc_ready  out  1  one-cycle completion pulse to DCache
- mem_req  out  1  memory access in progress
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid on the last BUSY cycle
- arb_busy  out  1  1 whenever state != IDLE (perf counter hook)

Behaviour:
- Reset clocking: reset is asynchronous, active-high; clock is clock.
- Reset values: state=IDLE, count=0, owner=IC, last_grant=IC.
- Reset values: all outputs 0, including rdata registers, mem_addr and mem_wdata.
- States: IDLE, BUSY, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one req: grant it.
- IDLE, both req: grant the requester that is not last_grant.
  - last_grant resets to IC, so the first conflict goes to DCache.
- Grant edge actions (IDLE->BUSY):
  - Capture owner, addr, we (forced 0 for IC) and wdata into registers.
  - Set last_grant=owner; count=0.
- BUSY:
  - mem_req=1; mem_addr, mem_we, mem_wdata driven from the captured registers, stable for the whole access.
  - count increments each cycle.
  - At count==MEM_LATENCY-1: register mem_rdata into rdata_q, then go to DONE.
- DONE (exactly one cycle):
  - mem_req=0; owner's ready=1; other ready=0; go to IDLE.
- ic_rdata and dc_rdata are both driven from rdata_q.
  - For a write, rdata_q is still loaded from mem_rdata; the DCache ignores it.
- Latency: req high in IDLE at cycle 0 -> mem_req high in cycles 1..MEM_LATENCY -> ready in cycle MEM_LATENCY+1.
- Requester contract:
  - Drop req in the cycle after its ready pulse.
  - The arbiter never samples req in DONE, so no double grant occurs.
- Requests arriving in BUSY or DONE wait; arbitration happens only in IDLE.
- Minimum gap between back-to-back grants is one IDLE cycle.
- Changes on addr/wdata after the grant edge are ignored.
- Reset mid-operation: immediate return to reset values.
  - No ready pulse is issued for the aborted access; mem_req drops asynchronously.
- Count width: 4 bits, which covers MEM_LATENCY up to 15.

Test Plan:
- Single read:
  - Stimulus: reset, then ic_req=1, ic_addr=0x0000_0040, mem_rdata=0xDEADBEEF_...01 on the last BUSY cycle.
  - Required: mem_req high cycles 1-5 with mem_addr=0x40 and mem_we=0; ic_ready=1 only at cycle 6 with that data; dc_ready stays 0.
- DCache write:
  - Stimulus: dc_req=1, dc_we=1, dc_addr=0x100, dc_wdata=0x1234.
  - Required: mem_we=1, mem_addr=0x100, mem_wdata=0x1234 for 5 cycles; dc_ready pulse at cycle 6.
- Conflict after reset:
  - Stimulus: ic_req and dc_req both high.
  - Required: DCache served first (ready cycle 6), then ICache granted at cycle 7 and ready at cycle 13.
- Alternation:
  - Stimulus: both requesters re-request immediately after each ready, for 4 transactions.
  - Required: grant order D, I, D, I.
- Late arrival:
  - Stimulus: dc_req rises at cycle 2 while an ICache access is BUSY.
  - Required: dc_addr not driven until after ic_ready; mem_addr unchanged during the ICache access.
- Reset mid-BUSY:
  - Stimulus: assert reset at cycle 3 of an access.
  - Required: mem_req, arb_busy and both ready outputs 0 immediately.
  - Required after release: a new ic_req completes in 6 cycles.
